data_cache: RTL and testbench

//  Direct-mapped, write-back, write-allocate data cache answering the control unit's READ/WRITE

---
 rtl/data_cache.sv | 153 +++++++++++++++
 tb/tb_data_cache.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_cache.sv
// ============================================================================
// Module   : data_cache
// Brief    : Direct-mapped write-back / write-allocate data cache with a
//            BUSYWAIT stall handshake toward the CPU and block-wide memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_cache #(
  parameter int INDEX_BITS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_read,
  input  logic        i_write,
  input  logic [7:0]  i_address,
  input  logic [7:0]  i_writedata,
  output logic [7:0]  o_readdata,
  output logic        o_busywait,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic [5:0]  o_mem_address,
  output logic [31:0] o_mem_writedata,
  input  logic [31:0] i_mem_readdata,
  input  logic        i_mem_busywait
);

  localparam int TAG_BITS = 6 - INDEX_BITS;
  localparam int NBLK     = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_ALLOCATE  = 2'd2,
    S_UPDATE    = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [31:0]         r_data  [NBLK];
  logic [TAG_BITS-1:0] r_tag   [NBLK];
  logic [NBLK-1:0]     r_valid;
  logic [NBLK-1:0]     r_dirty;

  logic [TAG_BITS-1:0]   r_miss_tag;
  logic [INDEX_BITS-1:0] r_miss_idx;
  logic [31:0]           r_fill;

  logic [TAG_BITS-1:0]   w_tag;
  logic [INDEX_BITS-1:0] w_idx;
  logic [1:0]            w_off;
  logic                  w_req;
  logic                  w_hit;

  assign w_tag = i_address[7:8-TAG_BITS];
  assign w_idx = i_address[INDEX_BITS+1:2];
  assign w_off = i_address[1:0];
  assign w_req = i_read | i_write;
  assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

  // On a simultaneous read/write hit this shows the byte before the store lands.
  assign o_readdata = w_hit ? r_data[w_idx][{w_off, 3'b000} +: 8] : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_valid    <= '0;
      r_dirty    <= '0;
      r_miss_tag <= '0;
      r_miss_idx <= '0;
      r_fill     <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_req && w_hit && i_write) begin
            r_dirty[w_idx] <= 1'b1;
          end
          if (w_req && !w_hit) begin
            r_miss_tag <= w_tag;
            r_miss_idx <= w_idx;
          end
        end
        S_ALLOCATE: begin
          if (!i_mem_busywait) begin
            r_fill <= i_mem_readdata;
          end
        end
        S_UPDATE: begin
          r_valid[r_miss_idx] <= 1'b1;
          r_dirty[r_miss_idx] <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Data and tag arrays are never cleared; valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == S_IDLE && w_req && w_hit && i_write) begin
        r_data[w_idx][{w_off, 3'b000} +: 8] <= i_writedata;
      end
      if (r_state == S_UPDATE) begin
        r_data[r_miss_idx] <= r_fill;
        r_tag[r_miss_idx]  <= r_miss_tag;
      end
    end
  end

  always_comb begin
    w_next          = r_state;
    o_busywait      = 1'b0;
    o_mem_read      = 1'b0;
    o_mem_write     = 1'b0;
    o_mem_address   = 6'h00;
    o_mem_writedata = 32'h0;
    case (r_state)
      S_IDLE: begin
        if (w_req && !w_hit) begin
          o_busywait = 1'b1;
          w_next     = r_dirty[w_idx] ? S_WRITEBACK : S_ALLOCATE;
        end
      end
      S_WRITEBACK: begin
        o_busywait      = 1'b1;
        o_mem_write     = 1'b1;
        o_mem_address   = {r_tag[r_miss_idx], r_miss_idx};
        o_mem_writedata = r_data[r_miss_idx];
        if (!i_mem_busywait) begin
          w_next = S_ALLOCATE;
        end
      end
      S_ALLOCATE: begin
        o_busywait    = 1'b1;
        o_mem_read    = 1'b1;
        o_mem_address = {r_miss_tag, r_miss_idx};
        if (!i_mem_busywait) begin
          w_next = S_UPDATE;
        end
      end
      S_UPDATE: begin
        o_busywait = 1'b1;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_data_cache.sv
// ============================================================================
// Module   : tb_data_cache
// Brief    : Randomized self-checking bench for data_cache against a flat
//            byte-memory reference and a 4-cycle-busy block memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_cache;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_read = 1'b0;
  logic        i_write = 1'b0;
  logic [7:0]  i_address = 8'h00;
  logic [7:0]  i_writedata = 8'h00;
  logic [7:0]  o_readdata;
  logic        o_busywait;
  logic        o_mem_read;
  logic        o_mem_write;
  logic [5:0]  o_mem_address;
  logic [31:0] o_mem_writedata;
  logic [31:0] w_mem_readdata;
  logic        w_mem_busywait;

  data_cache #(.INDEX_BITS(3)) u_dut (
    .clk             (clk),
    .rst             (rst),
    .i_read          (i_read),
    .i_write         (i_write),
    .i_address       (i_address),
    .i_writedata     (i_writedata),
    .o_readdata      (o_readdata),
    .o_busywait      (o_busywait),
    .o_mem_read      (o_mem_read),
    .o_mem_write     (o_mem_write),
    .o_mem_address   (o_mem_address),
    .o_mem_writedata (o_mem_writedata),
    .i_mem_readdata  (w_mem_readdata),
    .i_mem_busywait  (w_mem_busywait)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input int a);
    return 8'((a * 37 + 11) & 255);
  endfunction

  function automatic logic [31:0] init_blk(input int b);
    return {init_byte(b*4+3), init_byte(b*4+2), init_byte(b*4+1), init_byte(b*4)};
  endfunction

  // Block memory: busy for 4 cycles of each request, completes on the 5th edge.
  logic [31:0] r_mem_w [64];
  bit   [63:0] r_mem_wv;
  int          r_mem_cnt = 0;
  int          r_both_cnt = 0;
  logic        w_mem_req;

  assign w_mem_req      = o_mem_read | o_mem_write;
  assign w_mem_busywait = w_mem_req && (r_mem_cnt != 4);
  assign w_mem_readdata = r_mem_wv[o_mem_address] ? r_mem_w[o_mem_address]
                                                  : init_blk(int'(o_mem_address));

  always @(posedge clk) begin
    if (!w_mem_req) begin
      r_mem_cnt <= 0;
    end else if (r_mem_cnt == 4) begin
      r_mem_cnt <= 0;
      if (o_mem_write) begin
        r_mem_w[o_mem_address]  <= o_mem_writedata;
        r_mem_wv[o_mem_address] <= 1'b1;
      end
    end else begin
      r_mem_cnt <= r_mem_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (o_mem_read && o_mem_write) r_both_cnt <= r_both_cnt + 1;
  end

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: coherent byte view of memory plus cache occupancy for stall prediction.
  logic [7:0] m_flat  [256];
  bit         m_valid [8];
  bit         m_dirty [8];
  int         m_tag   [8];

  task automatic model_apply(input bit wr, input logic [7:0] a, input logic [7:0] d,
                             output int exp_stall, output logic [7:0] exp_rd);
    int idx;
    int tg;
    idx = (int'(a) / 4) % 8;
    tg  = int'(a) / 32;
    exp_stall = 0;
    if (!(m_valid[idx] && m_tag[idx] == tg)) begin
      exp_stall    = m_dirty[idx] ? 12 : 7;
      m_valid[idx] = 1;
      m_dirty[idx] = 0;
      m_tag[idx]   = tg;
    end
    exp_rd = m_flat[a];
    if (wr) begin
      m_flat[a]    = d;
      m_dirty[idx] = 1;
    end
  endtask

  int          t_stall;
  logic [7:0]  t_rdata;
  bit          t_saw_wb;
  bit          t_saw_rd;
  logic [5:0]  t_wb_addr;
  logic [31:0] t_wb_data;
  logic [5:0]  t_rd_addr;

  task automatic txn(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    i_read = rd; i_write = wr; i_address = a; i_writedata = d;
    #1;
    t_stall = 0; t_saw_wb = 0; t_saw_rd = 0;
    t_wb_addr = '0; t_wb_data = '0; t_rd_addr = '0;
    while (o_busywait && t_stall < 50) begin
      if (o_mem_write && !t_saw_wb) begin
        t_saw_wb = 1; t_wb_addr = o_mem_address; t_wb_data = o_mem_writedata;
      end
      if (o_mem_read && !t_saw_rd) begin
        t_saw_rd = 1; t_rd_addr = o_mem_address;
      end
      @(negedge clk); #1;
      t_stall++;
    end
    if (t_stall >= 50) check("stall_timeout", 32'(t_stall), 32'd0);
    t_rdata = o_readdata;
    @(posedge clk); #1;
    i_read = 0; i_write = 0;
  endtask

  task automatic run_checked(input string tag, input bit rd, input bit wr,
                             input logic [7:0] a, input logic [7:0] d);
    int         es;
    logic [7:0] er;
    model_apply(wr, a, d, es, er);
    txn(rd, wr, a, d);
    check({tag, "_stall"}, 32'(t_stall), 32'(es));
    check({tag, "_rdata"}, {24'h0, t_rdata}, {24'h0, er});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) m_flat[i] = init_byte(i);
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 0; m_dirty[i] = 0; m_tag[i] = 0;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_readdata", {24'h0, o_readdata}, 32'h0);
    check("rst_busywait", {31'h0, o_busywait}, 32'h0);
    check("rst_mem_req", {30'h0, o_mem_read, o_mem_write}, 32'h0);
    check("rst_mem_addr", {26'h0, o_mem_address}, 32'h0);
    check("rst_mem_wdata", o_mem_writedata, 32'h0);
    rst = 0;

    // Cold read miss
    run_checked("t1", 1, 0, 8'h05, 8'h00);
    check("t1_stall_abs", 32'(t_stall), 32'd7);
    check("t1_rdata_abs", {24'h0, t_rdata}, {24'h0, init_blk(1)[15:8]});
    check("t1_rd_seen", {31'h0, t_saw_rd}, 32'd1);
    check("t1_rd_addr", {26'h0, t_rd_addr}, 32'h01);
    check("t1_no_wb", {31'h0, t_saw_wb}, 32'd0);

    run_checked("t2", 1, 0, 8'h06, 8'h00);
    run_checked("t3w", 0, 1, 8'h05, 8'hAB);
    run_checked("t3r", 1, 0, 8'h05, 8'h00);
    check("t3_val", {24'h0, t_rdata}, 32'hAB);

    // Dirty eviction
    run_checked("t4", 1, 0, 8'h25, 8'h00);
    check("t4_stall_abs", 32'(t_stall), 32'd12);
    check("t4_wb_addr", {26'h0, t_wb_addr}, 32'h01);
    check("t4_wb_byte1", {24'h0, t_wb_data[15:8]}, 32'hAB);
    check("t4_rd_addr", {26'h0, t_rd_addr}, 32'h09);

    // Reset during ALLOCATE
    @(negedge clk);
    i_read = 1; i_address = 8'h05;
    repeat (3) @(negedge clk);
    #1;
    check("t5_in_alloc", {31'h0, o_mem_read}, 32'd1);
    rst = 1; i_read = 0;
    @(posedge clk); #1;
    check("t5_mem_read", {31'h0, o_mem_read}, 32'd0);
    check("t5_busywait", {31'h0, o_busywait}, 32'd0);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 0; m_dirty[i] = 0;
    end
    run_checked("t5r", 1, 0, 8'h25, 8'h00);
    check("t5_stall_abs", 32'(t_stall), 32'd7);

    // Simultaneous read+write on a hit
    run_checked("t6a", 1, 0, 8'h06, 8'h00);
    run_checked("t6b", 1, 1, 8'h06, 8'h3C);
    check("t6_stall_abs", 32'(t_stall), 32'd0);
    run_checked("t6c", 1, 0, 8'h06, 8'h00);
    check("t6_val", {24'h0, t_rdata}, 32'h3C);

    for (int n = 0; n < 200; n++) begin
      int         op;
      logic [7:0] a;
      logic [7:0] d;
      op = int'($urandom_range(0, 2));
      a  = 8'($urandom_range(0, 127));
      d  = 8'($urandom);
      run_checked("rnd", op != 1, op != 0, a, d);
    end

    check("mem_excl", 32'(r_both_cnt), 32'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
